// File: rtl/tetris_move_sched.sv
// rtl/tetris_move_sched.sv - falling-piece sequencer: button debounce, gravity, move req/ack arbitration, lock/respawn/game over
// Optional TETRIS_SOFT_DROP_EN: gravity runs 8x faster while the down button is held.
module tetris_move_sched #(
    parameter int CELL     = 20,
    parameter int X0       = 200,
    parameter int Y0       = 0,
    parameter int GRAV_DIV = 12_500_000,
    parameter int DEB_CYC  = 250_000
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       up,
    input  logic       left,
    input  logic       down,
    input  logic       right,
    output logic       mv_req,
    output logic [2:0] mv_dir,
    input  logic       mv_ack,
    input  logic       hit,
    output logic [9:0] ref_x,
    output logic [9:0] ref_y,
    output logic [3:0] shape,
    output logic       change_shape,
    output logic       stop
);

    localparam int GW = $clog2(GRAV_DIV + 1);
    localparam int DW = $clog2(DEB_CYC + 1);

    localparam logic [9:0] STEP    = 10'(CELL);
    localparam logic [9:0] SPAWN_X = 10'(X0);
    localparam logic [9:0] SPAWN_Y = 10'(Y0);

    localparam logic [2:0] DIR_PROBE = 3'd0;
    localparam logic [2:0] DIR_LEFT  = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_ROT   = 3'd4;

    localparam int B_UP    = 0;
    localparam int B_LEFT  = 1;
    localparam int B_DOWN  = 2;
    localparam int B_RIGHT = 3;

    localparam int P_ROT   = 0;
    localparam int P_LEFT  = 1;
    localparam int P_RIGHT = 2;
    localparam int P_DOWN  = 3;

    typedef enum logic [2:0] {
        S_SPAWN,
        S_IDLE,
        S_REQ,
        S_LOCK,
        S_OVER
    } state_t;

    state_t state, nxt;

    logic [3:0]    btn_raw, sync_a, sync_b, deb, press;
    logic [DW-1:0] deb_cnt [4];

    logic [GW-1:0] grav_cnt, grav_last;
    logic          grav_wrap;

    logic [3:0] pend, pend_set, grant, grant_clr;
    logic [2:0] sel_dir;
    logic       restart;

    logic [7:0] lfsr, lfsr_next;

    assign btn_raw = {right, down, left, up};

    // Buttons idle high, so the synchronizer and debounced level reset to 1.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            deb <= '1;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
                    deb[i]     <= sync_b[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is the cycle the debounced level commits to 0.
    always_comb begin
        press = '0;
        for (int i = 0; i < 4; i++) begin
            press[i] = (sync_b[i] != deb[i]) && (deb_cnt[i] == DW'(DEB_CYC - 1)) && !sync_b[i];
        end
    end

`ifdef TETRIS_SOFT_DROP_EN
    assign grav_last = deb[B_DOWN] ? GW'(GRAV_DIV - 1) : GW'(GRAV_DIV / 8 - 1);
`else
    assign grav_last = GW'(GRAV_DIV - 1);
`endif

    // >= rather than == so a shortened soft-drop period takes effect at once.
    assign grav_wrap = (state != S_OVER) && (grav_cnt >= grav_last);

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            grav_cnt <= '0;
        end else if (state == S_OVER || grav_wrap) begin
            grav_cnt <= '0;
        end else begin
            grav_cnt <= grav_cnt + 1'b1;
        end
    end

    assign pend_set = {press[B_DOWN] | grav_wrap, press[B_RIGHT], press[B_LEFT], press[B_UP]};
    assign restart  = (state == S_OVER) && press[B_UP];

    always_comb begin
        grant   = '0;
        sel_dir = DIR_PROBE;
        if (pend[P_ROT]) begin
            grant[P_ROT] = 1'b1;
            sel_dir      = DIR_ROT;
        end else if (pend[P_LEFT]) begin
            grant[P_LEFT] = 1'b1;
            sel_dir       = DIR_LEFT;
        end else if (pend[P_RIGHT]) begin
            grant[P_RIGHT] = 1'b1;
            sel_dir        = DIR_RIGHT;
        end else if (pend[P_DOWN]) begin
            grant[P_DOWN] = 1'b1;
            sel_dir       = DIR_DOWN;
        end
    end

    assign grant_clr = (state == S_IDLE) ? grant : 4'b0000;

    // A new press landing on its own grant cycle survives; lock and restart drop everything.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pend <= '0;
        end else if (state == S_LOCK || restart) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~grant_clr) | pend_set;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= S_SPAWN;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_SPAWN: nxt = S_REQ;
            S_IDLE: begin
                if (|pend) nxt = S_REQ;
            end
            S_REQ: begin
                if (mv_ack) begin
                    if (!hit)                    nxt = S_IDLE;
                    else if (mv_dir == DIR_DOWN)  nxt = S_LOCK;
                    else if (mv_dir == DIR_PROBE) nxt = S_OVER;
                    else                          nxt = S_IDLE;
                end
            end
            S_LOCK: nxt = S_SPAWN;
            S_OVER: begin
                if (press[B_UP]) nxt = S_SPAWN;
            end
            default: nxt = S_SPAWN;
        endcase
    end

    always_comb begin
        mv_req       = (state == S_REQ);
        change_shape = (state == S_LOCK);
        stop         = (state == S_OVER);
    end

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ref_x  <= SPAWN_X;
            ref_y  <= SPAWN_Y;
            shape  <= 4'd0;
            mv_dir <= DIR_PROBE;
            lfsr   <= 8'hA5;
        end else begin
            case (state)
                S_SPAWN: begin
                    ref_x  <= SPAWN_X;
                    ref_y  <= SPAWN_Y;
                    shape  <= {lfsr[1:0], 2'b00};
                    lfsr   <= lfsr_next;
                    mv_dir <= DIR_PROBE;
                end
                S_IDLE: begin
                    if (|pend) mv_dir <= sel_dir;
                end
                S_REQ: begin
                    if (mv_ack && !hit) begin
                        case (mv_dir)
                            DIR_LEFT:  ref_x      <= ref_x - STEP;
                            DIR_RIGHT: ref_x      <= ref_x + STEP;
                            DIR_DOWN:  ref_y      <= ref_y + STEP;
                            DIR_ROT:   shape[1:0] <= shape[1:0] + 2'd1;
                            default:   ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_move_sched.sv
// tb/tb_tetris_move_sched.sv - directed bench for tetris_move_sched with a 2-cycle-ack datapath model
module tb_tetris_move_sched;

    localparam int D_PROBE = 0;
    localparam int D_LEFT  = 1;
    localparam int D_RIGHT = 2;
    localparam int D_DOWN  = 3;
    localparam int D_ROT   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       up, left, down, right;
    logic       mv_ack, hit;
    logic       mv_req;
    logic [2:0] mv_dir;
    logic [9:0] ref_x, ref_y;
    logic [3:0] shape;
    logic       change_shape, stop;

    int         errors = 0;
    int         checks = 0;
    logic [4:0] hit_tbl = 5'b0;
    int         cmd_q[$];
    int         cs_cnt = 0;

    always #5 clk = ~clk;

    tetris_move_sched #(
        .CELL(20), .X0(200), .Y0(0), .GRAV_DIV(64), .DEB_CYC(4)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .up(up), .left(left), .down(down), .right(right),
        .mv_req(mv_req), .mv_dir(mv_dir), .mv_ack(mv_ack), .hit(hit),
        .ref_x(ref_x), .ref_y(ref_y), .shape(shape),
        .change_shape(change_shape), .stop(stop)
    );

    always @(negedge clk) begin
        if (change_shape === 1'b1) cs_cnt++;
    end

    // Datapath model: ack 2 cycles after req is seen, hit chosen per direction.
    initial begin : datapath
        int md;
        mv_ack = 1'b0;
        hit    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mv_req === 1'b1) begin
                md = int'(mv_dir);
                repeat (2) @(negedge clk);
                hit    = (md < 5) ? hit_tbl[md] : 1'b0;
                mv_ack = 1'b1;
                @(negedge clk);
                mv_ack = 1'b0;
                hit    = 1'b0;
                cmd_q.push_back(md);
            end
        end
    end

    task automatic wait_cmd(output int d, output bit ok);
        ok = 1'b0;
        d  = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_q.size() > 0) begin
                d  = cmd_q.pop_front();
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_dir(input int want, output bit found);
        int d;
        bit ok;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            wait_cmd(d, ok);
            if (!ok) break;
            if (d == want) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        int d;
        bit ok;
        rst_n = 1'b0;
        up = 1'b1; left = 1'b1; down = 1'b1; right = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mv_req !== 1'b0) begin errors++; $display("FAIL reset_mv_req got=%0b exp=0", mv_req); end
        checks++; if (mv_dir !== 3'd0) begin errors++; $display("FAIL reset_mv_dir got=%0d exp=0", mv_dir); end
        checks++; if (ref_x !== 10'd200) begin errors++; $display("FAIL reset_ref_x got=%0d exp=200", ref_x); end
        checks++; if (ref_y !== 10'd0) begin errors++; $display("FAIL reset_ref_y got=%0d exp=0", ref_y); end
        checks++; if (shape !== 4'd0) begin errors++; $display("FAIL reset_shape got=%0d exp=0", shape); end
        checks++; if (change_shape !== 1'b0) begin errors++; $display("FAIL reset_change_shape got=%0b exp=0", change_shape); end
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL reset_stop got=%0b exp=0", stop); end
        rst_n = 1'b1;
        wait_cmd(d, ok);
        checks++; if (!ok || d != D_PROBE) begin errors++; $display("FAIL reset_probe got=%0d exp=%0d", d, D_PROBE); end
        checks++; if (ref_x !== 10'd200 || ref_y !== 10'd0) begin errors++; $display("FAIL spawn_ref got=(%0d,%0d) exp=(200,0)", ref_x, ref_y); end
        checks++; if (shape !== 4'h4) begin errors++; $display("FAIL spawn_shape got=%0d exp=4", shape); end
        checks++; if (stop !== 1'b0 || mv_req !== 1'b0) begin errors++; $display("FAIL spawn_idle got stop=%0b req=%0b exp=0,0", stop, mv_req); end
    endtask

    task automatic test_reset_mid;
        int d;
        bit ok;
        bit seen;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mv_req === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_req_seen got=0 exp=1"); end
        rst_n = 1'b0;
        #1;
        checks++; if (mv_req !== 1'b0) begin errors++; $display("FAIL mid_reset_drop got=%0b exp=0", mv_req); end
        repeat (6) @(negedge clk);
        cmd_q.delete();
        rst_n = 1'b1;
        wait_cmd(d, ok);
        checks++; if (!ok || d != D_PROBE) begin errors++; $display("FAIL mid_reprobe got=%0d exp=%0d", d, D_PROBE); end
        checks++; if (shape !== 4'h4) begin errors++; $display("FAIL mid_shape got=%0d exp=4", shape); end
    endtask

    task automatic test_left_hold;
        int n_left;
        cmd_q.delete();
        left = 1'b0;
        repeat (20) @(negedge clk);
        left = 1'b1;
        repeat (20) @(negedge clk);
        n_left = 0;
        foreach (cmd_q[i]) if (cmd_q[i] == D_LEFT) n_left++;
        checks++; if (n_left != 1) begin errors++; $display("FAIL left_once got=%0d exp=1", n_left); end
        checks++; if (ref_x !== 10'd180) begin errors++; $display("FAIL left_ref_x got=%0d exp=180", ref_x); end
    endtask

    task automatic test_gravity;
        logic [9:0] y0;
        bit found;
        y0 = ref_y;
        cmd_q.delete();
        wait_dir(D_DOWN, found);
        checks++; if (!found) begin errors++; $display("FAIL grav_down got=none exp=DOWN"); end
        checks++; if (ref_y !== y0 + 10'd20) begin errors++; $display("FAIL grav_ref_y got=%0d exp=%0d", ref_y, y0 + 10'd20); end
        checks++; if (ref_x !== 10'd180) begin errors++; $display("FAIL grav_ref_x got=%0d exp=180", ref_x); end
    endtask

    task automatic test_lock;
        int d;
        bit ok;
        bit found;
        int cs0;
        cs0 = cs_cnt;
        cmd_q.delete();
        hit_tbl[D_DOWN] = 1'b1;
        wait_dir(D_DOWN, found);
        hit_tbl[D_DOWN] = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL lock_down got=none exp=DOWN"); end
        wait_cmd(d, ok);
        checks++; if (!ok || d != D_PROBE) begin errors++; $display("FAIL lock_probe got=%0d exp=%0d", d, D_PROBE); end
        checks++; if (cs_cnt - cs0 != 1) begin errors++; $display("FAIL lock_pulse got=%0d cycles exp=1", cs_cnt - cs0); end
        checks++; if (ref_x !== 10'd200 || ref_y !== 10'd0) begin errors++; $display("FAIL lock_ref got=(%0d,%0d) exp=(200,0)", ref_x, ref_y); end
        checks++; if (shape !== 4'h8) begin errors++; $display("FAIL lock_shape got=%0d exp=8", shape); end
    endtask

    task automatic test_simul_press;
        int d;
        bit ok;
        int n;
        int got [2];
        got[0] = -1;
        got[1] = -1;
        n = 0;
        cmd_q.delete();
        up = 1'b0;
        left = 1'b0;
        repeat (10) @(negedge clk);
        up = 1'b1;
        left = 1'b1;
        for (int k = 0; k < 6 && n < 2; k++) begin
            wait_cmd(d, ok);
            if (!ok) break;
            if (d != D_DOWN) begin
                got[n] = d;
                n++;
            end
        end
        checks++; if (got[0] != D_ROT) begin errors++; $display("FAIL prio_first got=%0d exp=%0d", got[0], D_ROT); end
        checks++; if (got[1] != D_LEFT) begin errors++; $display("FAIL prio_second got=%0d exp=%0d", got[1], D_LEFT); end
        checks++; if (shape !== 4'h9) begin errors++; $display("FAIL prio_shape got=%0d exp=9", shape); end
        checks++; if (ref_x !== 10'd180) begin errors++; $display("FAIL prio_ref_x got=%0d exp=180", ref_x); end
    endtask

    task automatic test_right_hit;
        bit found;
        int cs0;
        cs0 = cs_cnt;
        cmd_q.delete();
        hit_tbl[D_RIGHT] = 1'b1;
        right = 1'b0;
        repeat (8) @(negedge clk);
        right = 1'b1;
        wait_dir(D_RIGHT, found);
        hit_tbl[D_RIGHT] = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL right_hit_req got=none exp=RIGHT"); end
        checks++; if (ref_x !== 10'd180) begin errors++; $display("FAIL right_hit_discard got=%0d exp=180", ref_x); end
        checks++; if (cs_cnt != cs0 || stop !== 1'b0) begin errors++; $display("FAIL right_hit_nolock got lock=%0d stop=%0b exp=0,0", cs_cnt - cs0, stop); end
        repeat (10) @(negedge clk);
        cmd_q.delete();
        right = 1'b0;
        repeat (8) @(negedge clk);
        right = 1'b1;
        wait_dir(D_RIGHT, found);
        checks++; if (!found || ref_x !== 10'd200) begin errors++; $display("FAIL right_move got=%0d exp=200", ref_x); end
    endtask

    task automatic test_over;
        int d;
        bit ok;
        bit found;
        int reqs;
        cmd_q.delete();
        hit_tbl[D_DOWN]  = 1'b1;
        hit_tbl[D_PROBE] = 1'b1;
        wait_dir(D_DOWN, found);
        hit_tbl[D_DOWN] = 1'b0;
        wait_cmd(d, ok);
        hit_tbl[D_PROBE] = 1'b0;
        checks++; if (!found || !ok || d != D_PROBE) begin errors++; $display("FAIL over_probe got=%0d exp=%0d", d, D_PROBE); end
        @(negedge clk);
        checks++; if (stop !== 1'b1) begin errors++; $display("FAIL over_stop got=%0b exp=1", stop); end
        reqs = 0;
        repeat (200) begin
            @(negedge clk);
            if (mv_req !== 1'b0) reqs++;
        end
        checks++; if (reqs != 0) begin errors++; $display("FAIL over_quiet got=%0d req cycles exp=0", reqs); end
        checks++; if (stop !== 1'b1) begin errors++; $display("FAIL over_hold got=%0b exp=1", stop); end
        cmd_q.delete();
        up = 1'b0;
        repeat (10) @(negedge clk);
        up = 1'b1;
        wait_cmd(d, ok);
        checks++; if (!ok || d != D_PROBE) begin errors++; $display("FAIL restart_probe got=%0d exp=%0d", d, D_PROBE); end
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL restart_stop got=%0b exp=0", stop); end
        checks++; if (ref_x !== 10'd200 || ref_y !== 10'd0) begin errors++; $display("FAIL restart_ref got=(%0d,%0d) exp=(200,0)", ref_x, ref_y); end
        repeat (20) @(negedge clk);
        checks++; if (shape !== 4'h8) begin errors++; $display("FAIL restart_shape got=%0d exp=8", shape); end
    endtask

    initial begin
        rst_n = 1'b0;
        up = 1'b1; left = 1'b1; down = 1'b1; right = 1'b1;
        test_reset;
        test_reset_mid;
        test_left_hold;
        test_gravity;
        test_lock;
        test_simul_press;
        test_right_hit;
        test_over;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
